// File: rtl/logic_input_pipe.sv
// Multi-lane, depth-configurable input register chain with clock enable, valid tagging and primed status.
// Optional per-lane synchronous clear: define LOGIC_INPUT_PIPE_SCLR_EN.

module logic_input_pipe_lane #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    input  logic             ce,
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
    input  logic             sclr,
`endif
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic             primed
);

    if (DEPTH == 0) begin : g_pass
        // Pure wiring: the control inputs are intentionally ignored.
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
        logic unused_ok;
        assign unused_ok = ^{clk, rst, ce, sclr};
`else
        logic unused_ok;
        assign unused_ok = ^{clk, rst, ce};
`endif
        assign q      = d;
        assign q_vld  = d_vld;
        assign primed = 1'b1;
    end else begin : g_reg
        localparam int            CW   = $clog2(DEPTH + 1);
        localparam logic [CW-1:0] FULL = CW'(DEPTH);

        logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
        logic [DEPTH-1:0]            vld_q, vld_d;
        logic [CW-1:0]               fill_q, fill_d;

        always_comb begin
            data_d = data_q;
            vld_d  = vld_q;
            fill_d = fill_q;
            if (ce) begin
                data_d[0] = d;
                vld_d[0]  = d_vld;
                for (int k = 1; k < DEPTH; k++) begin
                    data_d[k] = data_q[k-1];
                    vld_d[k]  = vld_q[k-1];
                end
                if (fill_q != FULL) fill_d = fill_q + 1'b1;
            end
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
            // Clear wins over ce; the sample on this edge is dropped.
            if (sclr) begin
                data_d = '0;
                vld_d  = '0;
                fill_d = '0;
            end
`endif
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q <= '0;
                vld_q  <= '0;
                fill_q <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
                fill_q <= fill_d;
            end
        end

        assign q      = data_q[DEPTH-1];
        assign q_vld  = vld_q[DEPTH-1];
        assign primed = (fill_q == FULL);
    end

endmodule

module logic_input_pipe #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       d_vld,
    input  logic [CHANNELS-1:0]       ce,
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
    input  logic [CHANNELS-1:0]       sclr,
`endif
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       q_vld,
    output logic [CHANNELS-1:0]       primed,
    output logic                      any_vld
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic_input_pipe_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .d      (d[c*WIDTH +: WIDTH]),
            .d_vld  (d_vld[c]),
            .ce     (ce[c]),
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
            .sclr   (sclr[c]),
`endif
            .q      (q[c*WIDTH +: WIDTH]),
            .q_vld  (q_vld[c]),
            .primed (primed[c])
        );
    end

    assign any_vld = |q_vld;

endmodule

// File: tb/tb_logic_input_pipe.sv
// Randomized + directed bench: four DEPTH variants (0..3) share one stimulus stream and one history model.
module tb_logic_input_pipe;

    localparam int W  = 18;
    localparam int CH = 4;
    localparam int ND = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*W-1:0]   d;
    logic [CH-1:0]     d_vld, ce;
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
    logic [CH-1:0]     sclr;
`endif
    logic [CH*W-1:0]   q_w  [ND];
    logic [CH-1:0]     qv_w [ND];
    logic [CH-1:0]     pr_w [ND];
    logic              av_w [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic_input_pipe #(.WIDTH(W), .CHANNELS(CH), .DEPTH(g)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .d       (d),
            .d_vld   (d_vld),
            .ce      (ce),
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
            .sclr    (sclr),
`endif
            .q       (q_w[g]),
            .q_vld   (qv_w[g]),
            .primed  (pr_w[g]),
            .any_vld (av_w[g])
        );
    end

    // Model: every enabled sample since the last reset/clear, per lane.
    // A DEPTH-D lane shows the sample taken D enabled edges ago, else zero.
    logic [W:0] hist [CH][4096];
    int         cnt  [CH];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int dd = 0; dd < ND; dd++) begin
            logic [CH*W-1:0] eq;
            logic [CH-1:0]   ev, ep;
            for (int c = 0; c < CH; c++) begin
                if (dd == 0) begin
                    eq[c*W +: W] = d[c*W +: W];
                    ev[c] = d_vld[c];
                    ep[c] = 1'b1;
                end else if (cnt[c] >= dd) begin
                    {ev[c], eq[c*W +: W]} = hist[c][cnt[c]-dd];
                    ep[c] = 1'b1;
                end else begin
                    eq[c*W +: W] = '0;
                    ev[c] = 1'b0;
                    ep[c] = 1'b0;
                end
            end
            check($sformatf("%s_q_d%0d", tag, dd),      72'(q_w[dd]),  72'(eq));
            check($sformatf("%s_qvld_d%0d", tag, dd),   72'(qv_w[dd]), 72'(ev));
            check($sformatf("%s_primed_d%0d", tag, dd), 72'(pr_w[dd]), 72'(ep));
            check($sformatf("%s_anyvld_d%0d", tag, dd), 72'(av_w[dd]), 72'(|ev));
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) cnt[c] = 0;
    endtask

    // One clock edge: update the model from the inputs held across it, then check.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                logic clr;
                clr = 1'b0;
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
                clr = sclr[c];
`endif
                if (clr) cnt[c] = 0;
                else if (ce[c]) begin
                    hist[c][cnt[c]] = {d_vld[c], d[c*W +: W]};
                    cnt[c]++;
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        int pat [5];
        pat = '{1, 0, 1, 0, 0};
        rst = 1'b0; d = '0; d_vld = '0; ce = '0;
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
        sclr = '0;
`endif
        model_reset();
        #1;
        check_all("rst0");
        cyc("rst1");
        cyc("rst2");
        rst = 1'b1;

        // Fill: lane 0 gets 1..4, appears on the 3rd edge for DEPTH=3.
        ce = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            d = '0; d[17:0] = 18'(i); d_vld = 4'b0001;
            cyc("fill");
            if (i == 2) check("fill_not_primed", 72'(pr_w[3][0]), 72'd0);
            if (i == 3) begin
                check("fill_first_q", 72'(q_w[3][17:0]), 72'd1);
                check("fill_primed", 72'(pr_w[3][0]), 72'd1);
            end
            if (i == 4) check("fill_second_q", 72'(q_w[3][17:0]), 72'd2);
        end

        // Stall lane 1 for two cycles between the 2nd and 3rd sample.
        async_reset("stall_rst");
        cyc("stall_rsthold");
        rst = 1'b1;
        d_vld = 4'b0010;
        d = '0; d[35:18] = 18'd10; cyc("stall");
        d[35:18] = 18'd11; cyc("stall");
        ce = 4'b1101; d[35:18] = 18'd99;
        cyc("stall"); cyc("stall");
        check("stall_hold", 72'(q_w[3][35:18]), 72'd0);
        ce = 4'hF; d[35:18] = 18'd12; cyc("stall");
        check("stall_out", 72'(q_w[3][35:18]), 72'd10);

        // Async reset while lane 2 is showing 0x2AAAA.
        d = '0; d[53:36] = 18'h2AAAA; d_vld = 4'b0100;
        for (int i = 0; i < 3; i++) cyc("arst_fill");
        check("arst_pre", 72'(q_w[3][53:36]), 72'h2AAAA);
        async_reset("arst");
        check("arst_q", 72'(q_w[3]), 72'd0);
        check("arst_any", 72'(av_w[3]), 72'd0);
        check("arst_primed", 72'(pr_w[3]), 72'd0);
        cyc("arst_hold");
        rst = 1'b1;

`ifdef LOGIC_INPUT_PIPE_SCLR_EN
        // Clear lane 3 with ce also high; sample 5 must be dropped.
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < CH; c++) d[c*W +: W] = 18'($urandom);
            d_vld = 4'hF; cyc("sclr_fill");
        end
        sclr = 4'b1000; d[71:54] = 18'd5; cyc("sclr");
        check("sclr_q", 72'(q_w[3][71:54]), 72'd0);
        check("sclr_vld", 72'(qv_w[3][3]), 72'd0);
        check("sclr_primed", 72'(pr_w[3][3]), 72'd0);
        sclr = '0;
        for (int i = 0; i < 3; i++) begin
            d[71:54] = 18'(100 + i); cyc("sclr_refill");
        end
        check("sclr_reprimed", 72'(pr_w[3][3]), 72'd1);
        check("sclr_first", 72'(q_w[3][71:54]), 72'd100);
`endif

        // Valid tagging through DEPTH=2: lane 0 pattern 1,0,1 after an idle flush.
        ce = 4'hF; d_vld = '0; d = '0;
        cyc("tag_idle"); cyc("tag_idle"); cyc("tag_idle");
        for (int j = 0; j < 5; j++) begin
            d_vld = 4'(pat[j]); d[17:0] = 18'(j);
            cyc("tag");
            if (j >= 1) begin
                check("tag_qvld", 72'(qv_w[2]), 72'(pat[j-1]));
                check("tag_any", 72'(av_w[2]), 72'(pat[j-1]));
            end
        end

        // Randomized run with sparse clears and async resets.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) d[c*W +: W] = 18'($urandom);
            d_vld = 4'($urandom);
            ce    = 4'($urandom) | 4'($urandom);
`ifdef LOGIC_INPUT_PIPE_SCLR_EN
            sclr  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
`endif
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 149) == 0) async_reset("rnd_arst");
            cyc("rnd");
        end

        // Pass-through with reset asserted.
        async_reset("pt_rst");
        d = '0; d[17:0] = 18'h3FFFF; d_vld = 4'b0101;
        #1;
        check("pt_q", 72'(q_w[0][17:0]), 72'h3FFFF);
        check("pt_vld", 72'(qv_w[0]), 72'h5);
        check("pt_any", 72'(av_w[0]), 72'd1);
        check("pt_primed", 72'(pr_w[0]), 72'hF);
        check_all("pt");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
